// File: rtl/dvv_bridge_pkg.sv
// Shared types for the dvv bus bridge: FSM state encoding and the held response.
// DW here must match the DW the bridge is instantiated with.
package dvv_bridge_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } bridge_state_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

endpackage

// File: rtl/dvv_bus_bridge_if.sv
// Request, bus and response channels of the bridge. The bridge side uses the slave
// modport; the driver/bus-model/monitor side uses master.
interface dvv_bus_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid (and its payload) must stay asserted and stable until that edge.
  // bus_req is held with stable bus_we/addr/wdata until a one-cycle bus_ack.
  logic          req_vld;
  logic          req_rdy;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport slave (
    input  req_vld, req_we, req_addr, req_wdata, bus_ack, bus_rdata, rsp_rdy,
    output req_rdy, bus_req, bus_we, bus_addr, bus_wdata, rsp_vld, rsp_rdata, rsp_err
  );

  modport master (
    output req_vld, req_we, req_addr, req_wdata, bus_ack, bus_rdata, rsp_rdy,
    input  req_rdy, bus_req, bus_we, bus_addr, bus_wdata, rsp_vld, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dvv_tmo_cnt.sv
// Bus-wait counter: cleared when a request is accepted, counts BUS cycles without ack,
// done_o flags the last allowed cycle (count == TIMEOUT-1).
module dvv_tmo_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/dvv_bus_bridge.sv
// Single-outstanding request/response bridge onto a req/ack bus with timeout,
// plus running transaction and error counts.
module dvv_bus_bridge
  import dvv_bridge_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  dvv_bus_bridge_if.slave bif,
  output logic [15:0]     txn_cnt,
  output logic [15:0]     err_cnt,
  output bridge_state_t   state_o
);

  bridge_state_t state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  rsp_t          rsp_q, rsp_d;
  logic [15:0]   txn_q, txn_d;
  logic [15:0]   err_q, err_d;
  logic          tmo_clr, tmo_en, tmo_done;

  dvv_tmo_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmo_clr),
    .en_i   (tmo_en),
    .done_o (tmo_done)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsp_d   = rsp_q;
    txn_d   = txn_q;
    err_d   = err_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bif.req_vld) begin
          we_d    = bif.req_we;
          addr_d  = bif.req_addr;
          wdata_d = bif.req_wdata;
          tmo_clr = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // An ack on the final counted cycle still completes without error.
        if (bif.bus_ack) begin
          rsp_d.rdata = we_q ? '0 : bif.bus_rdata;
          rsp_d.err   = 1'b0;
          state_d     = RSP;
        end else if (tmo_done) begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          state_d     = RSP;
        end else begin
          tmo_en = 1'b1;
        end
      end
      RSP: begin
        if (bif.rsp_rdy) begin
          txn_d   = txn_q + 16'd1;
          err_d   = rsp_q.err ? err_q + 16'd1 : err_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
      txn_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
    end
  end

  assign bif.req_rdy   = (state_q == IDLE);
  assign bif.bus_req   = (state_q == BUS);
  assign bif.bus_we    = we_q & (state_q == BUS);
  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.rsp_vld   = (state_q == RSP);
  assign bif.rsp_rdata = rsp_q.rdata;
  assign bif.rsp_err   = rsp_q.err;
  assign txn_cnt       = txn_q;
  assign err_cnt       = err_q;
  assign state_o       = state_q;

endmodule
